// File: rtl/gpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpu_pkg
// Description : Shared scene-parameter constants, FSM state encoding and
//               named word addresses for the parameter commit path.
// Revision    : 1.0 - initial release
// ============================================================================
package gpu_pkg;

  localparam int NUM_WORDS_DEF  = 27;
  localparam int BYTE_COUNT_DEF = 2 * NUM_WORDS_DEF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_COMMIT  = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Word map: three vertices, normal, light, then viewport rows 0, 1 and 3.
  localparam logic [4:0] X_V0  = 5'd0;
  localparam logic [4:0] Y_V0  = 5'd1;
  localparam logic [4:0] Z_V0  = 5'd2;
  localparam logic [4:0] X_V1  = 5'd3;
  localparam logic [4:0] Y_V1  = 5'd4;
  localparam logic [4:0] Z_V1  = 5'd5;
  localparam logic [4:0] X_V2  = 5'd6;
  localparam logic [4:0] Y_V2  = 5'd7;
  localparam logic [4:0] Z_V2  = 5'd8;
  localparam logic [4:0] NX    = 5'd9;
  localparam logic [4:0] NY    = 5'd10;
  localparam logic [4:0] NZ    = 5'd11;
  localparam logic [4:0] LX    = 5'd12;
  localparam logic [4:0] LY    = 5'd13;
  localparam logic [4:0] LZ    = 5'd14;
  localparam logic [4:0] VP_00 = 5'd15;
  localparam logic [4:0] VP_01 = 5'd16;
  localparam logic [4:0] VP_02 = 5'd17;
  localparam logic [4:0] VP_03 = 5'd18;
  localparam logic [4:0] VP_10 = 5'd19;
  localparam logic [4:0] VP_11 = 5'd20;
  localparam logic [4:0] VP_12 = 5'd21;
  localparam logic [4:0] VP_13 = 5'd22;
  localparam logic [4:0] VP_30 = 5'd23;
  localparam logic [4:0] VP_31 = 5'd24;
  localparam logic [4:0] VP_32 = 5'd25;
  localparam logic [4:0] VP_33 = 5'd26;

  // Word holding a given host byte index.
  function automatic logic [4:0] word_of(input logic [5:0] byte_idx);
    return byte_idx[5:1];
  endfunction

endpackage
`default_nettype wire

// File: rtl/param_commit_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : param_commit_ctrl_if
// Description : Host byte stream, frame strobes and active-bank write port
//               of the parameter commit controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface param_commit_ctrl_if;

  logic        update_reg;
  logic [5:0]  idx;
  logic [7:0]  read_data;
  logic        pc_ready;
  logic        vblank_start;
  logic        ovr_clr;

  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;
  logic        pc_data_ready;
  logic        busy;
  logic        overrun;

  modport master (
    output update_reg, idx, read_data, pc_ready, vblank_start, ovr_clr,
    input  wr_en, wr_addr, wr_data, pc_data_ready, busy, overrun
  );

  modport slave (
    input  update_reg, idx, read_data, pc_ready, vblank_start, ovr_clr,
    output wr_en, wr_addr, wr_data, pc_data_ready, busy, overrun
  );

endinterface
`default_nettype wire

// File: rtl/shadow_regfile.sv
`default_nettype none
// ============================================================================
// Module      : shadow_regfile
// Description : Byte-writable shadow copy of the scene words; one byte write
//               port, one asynchronous word read port.
// Revision    : 1.0 - initial release
// ============================================================================
module shadow_regfile
  import gpu_pkg::*;
#(
  parameter int NUM_WORDS = NUM_WORDS_DEF
) (
  input  wire         clk,
  input  wire         rst,
  input  wire         i_we,
  input  wire  [5:0]  i_byte_idx,
  input  wire  [7:0]  i_byte_data,
  input  wire  [4:0]  i_raddr,
  output logic [15:0] o_rdata
);

  localparam logic [6:0] c_byte_count = 7'(2 * NUM_WORDS);

  logic [1:0][7:0] mem_q [NUM_WORDS];
  logic [1:0][7:0] mem_d [NUM_WORDS];
  logic            w_in_range;

  // Out-of-range byte indices are silently discarded.
  assign w_in_range = ({1'b0, i_byte_idx} < c_byte_count);

  always_comb begin
    mem_d = mem_q;
    if (i_we && w_in_range) begin
      mem_d[word_of(i_byte_idx)][i_byte_idx[0]] = i_byte_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule
`default_nettype wire

// File: rtl/param_commit_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : param_commit_ctrl
// Description : Collects host parameter bytes into a shadow buffer and copies
//               it word by word into the active bank once per frame.
//               Macro VBLANK_SYNC_EN: when defined the copy waits for
//               vblank_start; otherwise it starts one cycle after PENDING.
// Revision    : 1.0 - initial release
// ============================================================================
module param_commit_ctrl
  import gpu_pkg::*;
#(
  parameter int NUM_WORDS = NUM_WORDS_DEF
) (
  input wire             clk,
  input wire             reset,
  param_commit_ctrl_if.slave bus
);

  localparam logic [5:0] c_last_cnt = 6'(NUM_WORDS);

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        wr_en_q, wr_en_d;
  logic [4:0]  wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        pdr_q, pdr_d;
  logic        overrun_q, overrun_d;

  logic        w_idle;
  logic        w_shadow_we;
  logic        w_host_activity;
  logic        w_start_commit;
  logic [4:0]  w_rd_addr;
  logic [15:0] w_rd_data;

  assign w_idle          = (state_q == ST_IDLE);
  assign w_shadow_we     = w_idle && bus.update_reg;
  assign w_host_activity = bus.update_reg || bus.pc_ready;

`ifdef VBLANK_SYNC_EN
  assign w_start_commit = bus.vblank_start;
`else
  logic unused_vblank;
  assign w_start_commit = 1'b1;
  assign unused_vblank  = bus.vblank_start;
`endif

  // The shadow read address leads the registered write address by one cycle.
  assign w_rd_addr = ((state_q == ST_COMMIT) && (cnt_q < c_last_cnt)) ? cnt_q[4:0] : X_V0;

  shadow_regfile #(
    .NUM_WORDS (NUM_WORDS)
  ) u_shadow (
    .clk         (clk),
    .rst         (reset),
    .i_we        (w_shadow_we),
    .i_byte_idx  (bus.idx),
    .i_byte_data (bus.read_data),
    .i_raddr     (w_rd_addr),
    .o_rdata     (w_rd_data)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = '0;
    wr_data_d = '0;
    pdr_d     = 1'b0;
    overrun_d = overrun_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.pc_ready) begin
          state_d = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (w_start_commit) begin
          state_d   = ST_COMMIT;
          wr_en_d   = 1'b1;
          wr_addr_d = X_V0;
          wr_data_d = w_rd_data;
          cnt_d     = 6'd1;
        end
      end
      ST_COMMIT: begin
        if (cnt_q < c_last_cnt) begin
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q[4:0];
          wr_data_d = w_rd_data;
          cnt_d     = cnt_q + 6'd1;
        end else begin
          state_d = ST_DONE;
          pdr_d   = 1'b1;
          cnt_d   = '0;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A new overrun in the same cycle as the clear keeps the flag set.
    if (bus.ovr_clr) begin
      overrun_d = 1'b0;
    end
    if (!w_idle && w_host_activity) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      pdr_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      pdr_q     <= pdr_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.wr_en         = wr_en_q;
  assign bus.wr_addr       = wr_addr_q;
  assign bus.wr_data       = wr_data_q;
  assign bus.pc_data_ready = pdr_q;
  assign bus.busy          = (state_q == ST_PENDING) || (state_q == ST_COMMIT);
  assign bus.overrun       = overrun_q;

endmodule
`default_nettype wire

// File: doc/param_commit_ctrl.md
PARAM_COMMIT_CTRL -- requirements
Module: param_commit_ctrl

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 27, number of 16-bit Q8.8 scene words (vertices, normal, light, VP rows).
REQ-002 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port update_reg  input  1  one-cycle strobe: read_data valid for byte index idx.
REQ-005 SHALL have port idx  input  6  byte index 0..2*NUM_WORDS-1; even = low byte, odd = high byte of word idx>>1.
REQ-006 SHALL have port read_data  input  8  received byte.
REQ-007 SHALL have port pc_ready  input  1  one-cycle strobe: host frame of bytes complete.
REQ-008 SHALL have port vblank_start  input  1  one-cycle strobe at first line of vertical blank.
REQ-009 SHALL have port ovr_clr  input  1  clears the overrun flag.
REQ-010 SHALL have port wr_en  output  1  active-bank word write strobe.
REQ-011 SHALL have port wr_addr  output  5  active-bank word address.
REQ-012 SHALL have port wr_data  output  16  active-bank word data.
REQ-013 SHALL have port pc_data_ready  output  1  one-cycle pulse: active bank fully updated; starts vertex stage.
REQ-014 SHALL have port busy  output  1  high in PENDING and COMMIT.
REQ-015 SHALL have port overrun  output  1  sticky: host data arrived while not IDLE.

Function
REQ-016 SHALL hold a shadow buffer of NUM_WORDS x 16 bits, written only in IDLE.
REQ-017 SHALL, in IDLE on update_reg with idx < 2*NUM_WORDS, write read_data into the addressed byte of the shadow word on the next edge; idx >= 2*NUM_WORDS SHALL be ignored without error.
REQ-018 SHALL implement states IDLE, PENDING, COMMIT, DONE.
REQ-019 SHALL go IDLE->PENDING on pc_ready; an update_reg in the same cycle SHALL still be written.
REQ-020 SHALL go PENDING->COMMIT on vblank_start; vblank_start in any other state SHALL be ignored, including when coincident with pc_ready in IDLE.
REQ-021 SHALL, in COMMIT, assert wr_en for exactly NUM_WORDS consecutive cycles with wr_addr 0,1,..,NUM_WORDS-1 and wr_data = shadow[wr_addr], all registered.
REQ-022 SHALL, if vblank_start is seen at cycle T, produce wr_en at T+1..T+NUM_WORDS and pc_data_ready at T+NUM_WORDS+1 (DONE, one cycle), then IDLE.
REQ-023 SHALL drop update_reg bytes and pc_ready received in PENDING, COMMIT or DONE, and set overrun on the next edge.
REQ-024 SHALL clear overrun on ovr_clr; a simultaneous set condition SHALL win.
REQ-025 SHALL hold wr_en=0, wr_addr=0, wr_data=0 outside COMMIT.

Reset
REQ-026 SHALL, on reset, go to IDLE and clear the shadow buffer, word counter, overrun, busy, wr_en, wr_addr, wr_data and pc_data_ready to 0.
REQ-027 SHALL, on reset mid-COMMIT, abort immediately with no further wr_en and no pc_data_ready pulse.

Configuration
REQ-028 SHALL, with VBLANK_SYNC_EN defined, behave as in REQ-020.
REQ-029 SHALL, without VBLANK_SYNC_EN, stay in PENDING exactly one cycle then enter COMMIT unconditionally, ignoring vblank_start (commit begins cycle after pc_ready+1).

Structure
REQ-030 SHALL take NUM_WORDS default, byte count 2*NUM_WORDS, state encoding and named word addresses (X_V0=0 .. VP_33=26) from shared package gpu_pkg.
REQ-031 SHALL place the byte-writable shadow buffer in sub-module shadow_regfile (one byte-write port, one word read port).

Verification
REQ-032 SHALL verify: bytes idx 0..53 = 0x01..0x36, pc_ready, vblank_start at T -> wr_en T+1..T+27, word 0 = 0x0201, word 26 = 0x3635, pc_data_ready at T+28.
REQ-033 SHALL verify: update_reg idx=60 data 0xFF in IDLE -> shadow unchanged, overrun=0.
REQ-034 SHALL verify: byte idx=4 during COMMIT -> dropped, word 2 unchanged on next commit, overrun=1 until ovr_clr.
REQ-035 SHALL verify: pc_ready and vblank_start same cycle in IDLE -> PENDING, commit waits for next vblank_start.
REQ-036 SHALL verify: reset asserted at 10th wr_en -> wr_en=0 next cycle, no pc_data_ready, state IDLE, shadow all zero.
REQ-037 SHALL verify: without VBLANK_SYNC_EN, pc_ready at T -> wr_en T+2..T+28, pc_data_ready at T+29.
